fifo_2_axis_adapter: RTL
========================

# fifo_2_axis_adapter

Drains a synchronous FIFO whose words are packed as {tuser, tlast, tdata} and presents them as an AXI-Stream master. It sits directly downstream of the FIFO fed by the AXIS-to-FIFO write adapter and restores the stream on the read side. It absorbs the FIFO's one-cycle read latency with a 2-entry output buffer, so it sustains one beat per clock under continuous tready. It also counts completed frames.

## Interface
- AXIS_DATA_WIDTH, 32, tdata width
- FIFO_DATA_WIDTH, AXIS_DATA_WIDTH + 2, FIFO word width; the bit layout is [MSB]=tuser, [MSB-1]=tlast, [AXIS_DATA_WIDTH-1:0]=tdata
- COUNT_WIDTH, 16, width of the frame counter

Ports:
- clk  in  1  single clock; all logic is on the rising edge
- rst  in  1  asynchronous, active-low reset
- i_fifo_data  in  FIFO_DATA_WIDTH  FIFO read data; valid the cycle after o_fifo_r_stb
- o_fifo_r_stb  out  1  FIFO read strobe; pops one word per cycle when high
- i_fifo_empty  in  1  FIFO empty flag
- i_fifo_not_empty  in  1  FIFO not-empty flag
- o_axis_tuser  out  1  unpacked tuser of the head entry
- o_axis_tvalid  out  1  head entry valid
- i_axis_tready  in  1  downstream ready
- o_axis_tlast  out  1  unpacked tlast of the head entry
- o_axis_tdata  out  AXIS_DATA_WIDTH  unpacked tdata of the head entry
- o_frame_count  out  COUNT_WIDTH  number of beats accepted with tlast=1; wraps modulo 2^COUNT_WIDTH
- o_idle  out  1  high when the buffer is empty, no read is in flight, and i_fifo_empty=1

## Operation
- State: a 2-entry buffer (head entry and tail entry), `occ` (0..2), `inflight` (0/1, a read was issued last cycle), and the frame counter.
- pop = o_axis_tvalid & i_axis_tready.
- o_fifo_r_stb = rst & i_fifo_not_empty & ~i_fifo_empty & ((occ + inflight - pop) < 2). This path is combinational from i_axis_tready.
- The o_fifo_r_stb condition is a credit rule: it is never asserted when the buffer plus the in-flight word would exceed 2. Buffer overflow is therefore impossible by construction.
- inflight <= o_fifo_r_stb every cycle.
- When inflight=1, i_fifo_data is written to the buffer on that edge. If occ after any pop is 0, it goes to the head entry; otherwise it goes to the tail entry.
- On pop with occ=2, the tail entry moves to the head entry. If a push happens in the same cycle, the pushed word goes to the tail entry.
- Simultaneous push and pop leaves occ unchanged. Push only raises occ by 1. Pop only lowers occ by 1.
- o_axis_tvalid = (occ != 0). o_axis_tdata, o_axis_tlast and o_axis_tuser come from the head entry and are registered.
- On pop with o_axis_tlast=1, o_frame_count increments. From all-ones it wraps to 0.
- i_fifo_data is ignored in any cycle where inflight=0.

## Timing
- Reset (rst=0, asynchronous assert, synchronous deassert handled by the system) puts every signal in this state:
  - occ=0, inflight=0, o_axis_tvalid=0, o_axis_tdata=0, o_axis_tlast=0, o_axis_tuser=0, o_frame_count=0.
  - o_fifo_r_stb=0 during reset. o_idle reflects i_fifo_empty.
- Reset mid-operation discards the buffered words and any in-flight word. The FIFO word already popped is lost; this is by design.
- Latency: if i_fifo_not_empty rises in cycle N with the buffer empty, o_fifo_r_stb=1 in cycle N, the word is captured at the end of N+1, and o_axis_tvalid=1 in cycle N+2.
- Throughput: with continuous tready and a non-empty FIFO, steady state is occ=1, inflight=1, one beat per cycle with no bubbles.
- AXIS rules:
  - Once o_axis_tvalid is high, it stays high and tdata, tlast and tuser stay stable until pop.
  - tvalid never depends combinationally on tready.
- Backpressure: with tready=0, at most 2 words are buffered. The last o_fifo_r_stb occurs when occ + inflight reaches 2, and there are no further reads.
- FIFO empties mid-stream: o_fifo_r_stb drops in the same cycle. The buffered words still drain.

## Test plan
- Reset, single word: hold rst=0, then release; FIFO holds one word {1,1,0xDEADBEEF}. Required:
  - r_stb pulses for 1 cycle.
  - tvalid rises 2 cycles after r_stb, with tuser=1, tlast=1, tdata=0xDEADBEEF.
  - After pop, o_frame_count=1 and o_idle=1.
- Streaming: 64 words 0..63 with tlast on 15/31/47/63 and tready=1. Required:
  - 64 consecutive beats with no gaps after the first beat, in order.
  - o_frame_count=4 at the end.
- Backpressure: 10 words in the FIFO, tready=0 for 20 cycles. Required:
  - Exactly 2 r_stb pulses, occ=2, and tdata held at word 0 and stable throughout.
  - After tready=1, all 10 words come out in order with none lost or duplicated.
- Random tready (50%) with the FIFO refilled randomly, 1000 words. Required:
  - The output sequence equals the input sequence.
  - r_stb is never high while i_fifo_empty=1.
- Wrap: COUNT_WIDTH=4, 17 single-beat frames. Required: o_frame_count=1 at the end.
- Reset mid-stream: rst=0 asserted while occ=2 and inflight=1. Required:
  - tvalid=0, o_frame_count=0 and r_stb=0 immediately on assertion.
  - After rst=1, the next output is the next FIFO word.

Source files
------------

// File: rtl/fifo_2_axis_adapter.sv
// fifo_2_axis_adapter: drains a {tuser,tlast,tdata} FIFO into an AXI-Stream master through a 2-entry buffer
module fifo_2_axis_adapter #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int FIFO_DATA_WIDTH = AXIS_DATA_WIDTH + 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [FIFO_DATA_WIDTH-1:0] i_fifo_data,
  output logic                       o_fifo_r_stb,
  input  logic                       i_fifo_empty,
  input  logic                       i_fifo_not_empty,
  output logic                       o_axis_tuser,
  output logic                       o_axis_tvalid,
  input  logic                       i_axis_tready,
  output logic                       o_axis_tlast,
  output logic [AXIS_DATA_WIDTH-1:0] o_axis_tdata,
  output logic [COUNT_WIDTH-1:0]     o_frame_count,
  output logic                       o_idle
);
  logic [FIFO_DATA_WIDTH-1:0] head, tail;
  logic [1:0] occ, occ_pop;
  logic inflight, pop;
  assign pop = o_axis_tvalid & i_axis_tready;
  assign occ_pop = occ - {1'b0, pop};
  // credit rule: a new read only when buffered plus in-flight words stay below 2
  assign o_fifo_r_stb = rst & i_fifo_not_empty & ~i_fifo_empty & ((occ_pop + {1'b0, inflight}) < 2'd2);
  assign o_axis_tvalid = occ != 2'd0;
  assign o_axis_tuser = head[FIFO_DATA_WIDTH-1];
  assign o_axis_tlast = head[FIFO_DATA_WIDTH-2];
  assign o_axis_tdata = head[AXIS_DATA_WIDTH-1:0];
  assign o_idle = (occ == 2'd0) & ~inflight & i_fifo_empty;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      occ <= '0;
      inflight <= 1'b0;
      o_frame_count <= '0;
    end else begin
      inflight <= o_fifo_r_stb;
      occ <= occ_pop + {1'b0, inflight};
      if (pop && occ == 2'd2) head <= tail;
      if (inflight && occ_pop == 2'd0) head <= i_fifo_data;
      if (inflight && occ_pop != 2'd0) tail <= i_fifo_data;
      if (pop && o_axis_tlast) o_frame_count <= o_frame_count + COUNT_WIDTH'(1);
    end
  end
endmodule
